// File: rtl/led_breathe.sv
// Breathing-LED driver: a prescaler paces a brightness level through a
// ramp-up / hold-high / ramp-down / hold-low cycle, and a free-running PWM
// counter turns that level into a registered LED drive.
module led_breathe #(
    parameter int unsigned CLK_FREQ       = 100_000_000,
    parameter int unsigned PWM_BITS       = 8,
    parameter int unsigned RAMP_STEP_CLKS = 195_312,
    parameter int unsigned HOLD_STEPS     = 64
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                en,
    output logic                LED,
    output logic [PWM_BITS-1:0] level,
    output logic                cycle_done
);

    // Counter widths never drop below one bit so the degenerate
    // single-clock step and single-step hold still elaborate.
    localparam int unsigned PreW  = (RAMP_STEP_CLKS > 1) ? $clog2(RAMP_STEP_CLKS) : 1;
    localparam int unsigned HoldW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

    localparam logic [PreW-1:0]     PreLast  = PreW'(RAMP_STEP_CLKS - 1);
    localparam logic [HoldW-1:0]    HoldLast = HoldW'(HOLD_STEPS - 1);
    localparam logic [PWM_BITS-1:0] LevelMax = '1;

    // Parameter sanity; CLK_FREQ is informational and only checked here.
    if (CLK_FREQ == 0) begin : g_bad_clk_freq
        $error("led_breathe: CLK_FREQ must be non-zero");
    end
    if (RAMP_STEP_CLKS < 1) begin : g_bad_ramp
        $error("led_breathe: RAMP_STEP_CLKS must be >= 1");
    end
    if (HOLD_STEPS < 1) begin : g_bad_hold
        $error("led_breathe: HOLD_STEPS must be >= 1");
    end

    typedef enum logic [1:0] {
        StRampUp,
        StHighHold,
        StRampDown,
        StLowHold
    } state_e;

    logic [PreW-1:0]     pre_q;
    logic [PWM_BITS-1:0] pwm_q;
    logic [PWM_BITS-1:0] level_q;
    logic [HoldW-1:0]    hold_q;
    state_e              state_q;
    logic                led_q;
    logic                done_q;
    logic                step;

    // en low suppresses the step, so en wins over a coincident terminal count.
    assign step = en && (pre_q == PreLast);

    // Prescaler: counts while enabled, wraps on step, cleared while disabled.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            pre_q <= '0;
        end else if (!en || step) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + 1'b1;
        end
    end

    // Free-running PWM counter, independent of en.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            pwm_q <= '0;
        end else begin
            pwm_q <= pwm_q + 1'b1;
        end
    end

    // Registered PWM compare; blanked while disabled.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            led_q <= 1'b0;
        end else begin
            led_q <= en && (pwm_q < level_q);
        end
    end

    // Breath state machine; advances only on step, so en=0 freezes it.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= StRampUp;
            level_q <= '0;
            hold_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (step) begin
                unique case (state_q)
                    StRampUp: begin
                        if (level_q == LevelMax) begin
                            state_q <= StHighHold;
                            hold_q  <= '0;
                        end else begin
                            level_q <= level_q + 1'b1;
                        end
                    end
                    StHighHold: begin
                        if (hold_q == HoldLast) begin
                            state_q <= StRampDown;
                        end else begin
                            hold_q <= hold_q + 1'b1;
                        end
                    end
                    StRampDown: begin
                        if (level_q == '0) begin
                            state_q <= StLowHold;
                            hold_q  <= '0;
                        end else begin
                            level_q <= level_q - 1'b1;
                        end
                    end
                    StLowHold: begin
                        if (hold_q == HoldLast) begin
                            state_q <= StRampUp;
                            done_q  <= 1'b1;
                        end else begin
                            hold_q <= hold_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= StRampUp;
                    end
                endcase
            end
        end
    end

    assign LED        = led_q;
    assign level      = level_q;
    assign cycle_done = done_q;

endmodule

// File: doc/led_breathe.md
# led_breathe

Breathing-LED driver that sits directly downstream of the board clock and drives a single LED pin. It replaces a hard on/off blink with a smooth brightness ramp. An internal prescaler paces a brightness level up and down through a four-state machine. A free-running PWM counter converts the current level into a registered LED drive. A one-cycle pulse marks the end of each full breath, so a top level can chain or count cycles.

## Interface
- CLK_FREQ, 100_000_000: input clock frequency in Hz; documentation only, not used in arithmetic.
- PWM_BITS, 8: width of the brightness level and PWM counter; max level is 2^PWM_BITS-1.
- RAMP_STEP_CLKS, 195_312: clocks per brightness step; default gives a ~0.5 s ramp at 100 MHz; must be ≥1.
- HOLD_STEPS, 64: steps spent at full and at zero brightness; must be ≥1.

- CLK  input  1  system clock; all logic on rising edge.
- RST_N  input  1  reset; one clock; reset is synchronous and active-low.
- en  input  1  run enable; low freezes the breath and blanks the LED.
- LED  output  1  registered PWM drive, high = lit.
- level  output  PWM_BITS  current brightness level.
- cycle_done  output  1  one-clock pulse at the end of each full breath.

## Operation
- **Prescaler.**
  - Counts 0..RAMP_STEP_CLKS-1 while en=1.
  - `step` asserts on the cycle the count equals RAMP_STEP_CLKS-1; the count then wraps to 0.
  - en=0 clears the prescaler to 0. No step occurs while en=0.
- **PWM counter.**
  - Free-running, PWM_BITS wide, wraps naturally; runs regardless of en.
  - Compare is pwm_cnt < level: level 0 is never lit; max level is lit (2^PWM_BITS-1) of every 2^PWM_BITS clocks.
- **State machine.** States RAMP_UP, HIGH_HOLD, RAMP_DOWN, LOW_HOLD. All transitions occur only on `step`.
  - RAMP_UP: if level==max, go to HIGH_HOLD and clear hold_cnt; else level+1.
  - HIGH_HOLD: if hold_cnt==HOLD_STEPS-1, go to RAMP_DOWN; else hold_cnt+1.
  - RAMP_DOWN: if level==0, go to LOW_HOLD and clear hold_cnt; else level-1.
  - LOW_HOLD: if hold_cnt==HOLD_STEPS-1, go to RAMP_UP and pulse cycle_done; else hold_cnt+1.
- **Arithmetic.**
  - Level never wraps: increment is gated at max, decrement is gated at 0.
  - hold_cnt is wide enough for HOLD_STEPS-1.
- **Full breath length.** 2·(2^PWM_BITS + HOLD_STEPS) steps, i.e. ×RAMP_STEP_CLKS clocks.
- **en=0.**
  - State, level and hold_cnt are held.
  - LED is forced 0 from the next clock.
  - When en returns to 1, the breath resumes from the held state with a fresh prescaler count.
- **Reset values** (RST_N low at a rising edge): state=RAMP_UP, level=0, hold_cnt=0, prescaler=0, pwm_cnt=0, LED=0, cycle_done=0.
- **Reset mid-operation** aborts the breath immediately, with no cycle_done pulse.

## Timing
- level and state update on the clock edge where `step` is high; the new level is visible the following cycle.
- LED is registered: it reflects (pwm_cnt < level) && en sampled one clock earlier.
- cycle_done is high for exactly one clock, coincident with the first cycle in which state=RAMP_UP after LOW_HOLD.
- After RST_N deasserts, the first step occurs RAMP_STEP_CLKS clocks later.
- If en falls on the same cycle `step` would fire, en wins: no transition occurs.
- Reset overrides en and `step` in all cases.

## Test plan
Unless noted, parameters are PWM_BITS=3, RAMP_STEP_CLKS=4, HOLD_STEPS=2.

- **Reset:** hold RST_N=0 for 3 clocks with en=1, then release → LED=0, level=0, cycle_done=0 throughout reset; level becomes 1 exactly 4 clocks after release.
- **Full breath:** run with en=1 → level sequence 0..7, holds at 7 for 3 steps (the transition step plus HOLD_STEPS=2), ramps 7..0, holds at 0 for 3 steps; cycle_done pulses once at step 20 (clock 80 after release), then repeats every 80 clocks.
- **PWM duty:** freeze at level=5 via en toggling, then check en=1 with a fixed level → LED high 5 of every 8 clocks, lagging the pwm_cnt compare by one clock; level=0 gives LED never high; level=7 gives 7/8.
- **Enable freeze:** drop en for 50 clocks mid RAMP_DOWN at level=4 → LED=0 from the next clock, level stays 4; after en returns, level becomes 3 exactly 4 clocks later.
- **Reset mid-breath:** assert RST_N=0 during HIGH_HOLD → next clock level=0, state=RAMP_UP, no cycle_done pulse.
- **Extreme parameters:** RAMP_STEP_CLKS=1, HOLD_STEPS=1 → a step every clock; full breath is 18 clocks; cycle_done period is 18; level never exceeds 7 or underflows below 0.
